// File: rtl/sdram_arbiter_n.sv
// sdram_arbiter_n
//   N-channel request arbiter in front of the SDRAM controller. Each client
//   channel raises an edge-triggered request; the arbiter latches it, picks a
//   winner when the controller is idle (fixed priority, channel 0 highest,
//   with aging so a channel that keeps losing is eventually promoted), issues
//   one registered command and returns a one-cycle DONE pulse with the read
//   data captured per channel. A ROM-download write path bypasses arbitration.
//
// Ports
//   CLK, nRESET                 clock, synchronous active-low reset
//   CH_REQ/WE/BURST             per-channel request edge, write flag, burst flag
//   CH_ADDR/DIN/BS              per-channel address, write data, byte strobes
//   CH_DOUT/DONE/PEND           per-channel read data, completion, busy status
//   SDRAM_RD/WR/BURST           controller command
//   SDRAM_ADDR/DIN/BS           controller command payload
//   SDRAM_DOUT, SDRAM_READY     controller read data and idle flag
//   DL_EN/WR/ADDR/DATA          ROM download bypass
module sdram_arbiter_n #(
  parameter int NCH     = 4,
  parameter int AW      = 26,
  parameter int RDW     = 64,
  parameter int AGE_MAX = 8
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic [NCH-1:0]       CH_REQ,
  input  logic [NCH-1:0]       CH_WE,
  input  logic [NCH-1:0]       CH_BURST,
  input  logic [NCH*AW-1:0]    CH_ADDR,
  input  logic [NCH*16-1:0]    CH_DIN,
  input  logic [NCH*2-1:0]     CH_BS,
  output logic [NCH*RDW-1:0]   CH_DOUT,
  output logic [NCH-1:0]       CH_DONE,
  output logic [NCH-1:0]       CH_PEND,
  output logic                 SDRAM_RD,
  output logic                 SDRAM_WR,
  output logic                 SDRAM_BURST,
  output logic [AW-1:0]        SDRAM_ADDR,
  output logic [15:0]          SDRAM_DIN,
  output logic [1:0]           SDRAM_BS,
  input  logic [RDW-1:0]       SDRAM_DOUT,
  input  logic                 SDRAM_READY,
  input  logic                 DL_EN,
  input  logic                 DL_WR,
  input  logic [AW-1:0]        DL_ADDR,
  input  logic [15:0]          DL_DATA
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AGEW = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
  localparam logic [AGEW-1:0] AGE_LIM = AGEW'(AGE_MAX);

  logic [1:0]      state;
  logic            old_ready;
  logic [NCH-1:0]  req_d;
  logic [NCH-1:0]  pend;
  logic            run_vld;
  logic [CW-1:0]   run_ch;
  logic            run_we;
  logic [AGEW-1:0] age     [NCH];
  logic [AGEW-1:0] age_nxt [NCH];

  logic [NCH-1:0]  req_edge;
  logic [NCH-1:0]  pend_now;
  logic [NCH-1:0]  pend_nxt;
  logic [NCH-1:0]  run_mask;
  logic [NCH-1:0]  cand;
  logic [CW-1:0]   win_base;
  logic [CW-1:0]   win_aged;
  logic            any_aged;
  logic [CW-1:0]   win;
  logic            arb_en;
  logic            grant;
  logic            comp;
  logic            dl_load;

  // Saturating age counter step.
  function automatic logic [AGEW-1:0] age_inc(input logic [AGEW-1:0] a);
    return (a == AGE_LIM) ? a : a + 1'b1;
  endfunction

  // Clients that drive no strobes mean a full-word access.
  function automatic logic [1:0] bs_norm(input logic [1:0] bs);
    return (bs == 2'b00) ? 2'b11 : bs;
  endfunction

  // A fresh edge is usable in the cycle it arrives, so the candidate set
  // looks at the edge directly instead of waiting for pend to register it.
  assign req_edge = CH_REQ & ~req_d;
  assign pend_now = pend | req_edge;
  assign dl_load  = DL_EN & DL_WR;
  assign arb_en   = (state == ST_IDLE) && SDRAM_READY && !DL_EN && nRESET;
  assign comp     = (state == ST_IDLE) && run_vld && nRESET;

  always_comb begin
    run_mask = '0;
    if (run_vld) run_mask[run_ch] = 1'b1;
  end

  assign cand    = pend_now & ~run_mask;
  assign grant   = arb_en && (|cand);
  assign CH_PEND = pend | run_mask;

  // Scan from the top down so the lowest index ends up selected.
  always_comb begin
    win_base = '0;
    win_aged = '0;
    any_aged = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) win_base = CW'(i);
      if (cand[i] && (AGE_MAX != 0) && (age[i] == AGE_LIM)) begin
        win_aged = CW'(i);
        any_aged = 1'b1;
      end
    end
    win = any_aged ? win_aged : win_base;
  end

  always_comb begin
    pend_nxt = pend_now;
    if (comp) pend_nxt[run_ch] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      age_nxt[i] = age[i];
      if (grant && cand[i]) age_nxt[i] = (CW'(i) == win) ? '0 : age_inc(age[i]);
      if (!pend_now[i]) age_nxt[i] = '0;
    end
  end

  // Command FSM. A reset during a download keeps a download write alive.
  always_ff @(posedge CLK) begin
    old_ready <= SDRAM_READY;
    if (!nRESET && !DL_EN) begin
      state    <= ST_IDLE;
      SDRAM_RD <= 1'b0;
      SDRAM_WR <= 1'b0;
    end else if (dl_load) begin
      state    <= ST_CMD;
      SDRAM_RD <= 1'b0;
      SDRAM_WR <= 1'b1;
    end else if (grant) begin
      state    <= ST_CMD;
      SDRAM_RD <= ~CH_WE[win];
      SDRAM_WR <= CH_WE[win];
    end else begin
      case (state)
        ST_IDLE: ;
        ST_CMD: begin
          // The controller acknowledges by dropping READY.
          if (old_ready && !SDRAM_READY) begin
            SDRAM_RD <= 1'b0;
            SDRAM_WR <= 1'b0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: if (SDRAM_READY) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Channel bookkeeping: request latch, aging, completion and read capture.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      req_d       <= CH_REQ;
      pend        <= '0;
      run_vld     <= 1'b0;
      run_ch      <= '0;
      run_we      <= 1'b0;
      CH_DONE     <= '0;
      CH_DOUT     <= '0;
      SDRAM_BURST <= 1'b0;
      SDRAM_BS    <= 2'b11;
      for (int i = 0; i < NCH; i++) age[i] <= '0;
    end else begin
      req_d   <= CH_REQ;
      pend    <= pend_nxt;
      CH_DONE <= '0;
      for (int i = 0; i < NCH; i++) age[i] <= age_nxt[i];
      if (comp) begin
        CH_DONE[run_ch] <= 1'b1;
        if (!run_we) CH_DOUT[int'(run_ch)*RDW +: RDW] <= SDRAM_DOUT;
      end
      if (grant) begin
        run_vld <= 1'b1;
        run_ch  <= win;
        run_we  <= CH_WE[win];
      end else if (comp) begin
        run_vld <= 1'b0;
      end
      if (dl_load) begin
        SDRAM_BURST <= 1'b0;
        SDRAM_BS    <= 2'b11;
      end else if (grant) begin
        SDRAM_BURST <= CH_BURST[win] & ~CH_WE[win];
        SDRAM_BS    <= bs_norm(CH_BS[int'(win)*2 +: 2]);
      end
    end
  end

  // Command payload: pure data, loaded on download write or grant.
  always_ff @(posedge CLK) begin
    if (dl_load) begin
      SDRAM_ADDR <= DL_ADDR;
      SDRAM_DIN  <= DL_DATA;
    end else if (grant) begin
      SDRAM_ADDR <= CH_ADDR[int'(win)*AW +: AW];
      SDRAM_DIN  <= CH_DIN[int'(win)*16 +: 16];
    end
  end

endmodule

// File: doc/sdram_arbiter_n.md
Name: sdram_arbiter_n

Overview:
- Parametrised N-channel SDRAM request arbiter; next generation of the fixed 68k/CROM/SROM/CD SDRAM mux.
- Each client (68k/P-ROM, sprite, fix, CD DMA, future ADPCM) gets a generic channel: edge-triggered request, read/write, burst flag, byte strobes and registered read data.
- Sits between the NeoGeo core clients and the SDRAM controller. Adds priority aging so low-priority channels cannot starve. Keeps the loader-write bypass.

Parameters:
NCH, 4, number of client channels; channel 0 has highest base priority
AW, 26, SDRAM word address width (bit 1 upward)
RDW, 64, SDRAM read data width (burst word)
AGE_MAX, 8, number of lost grants before a pending channel is promoted; 0 disables aging

Ports:
CLK  in  1  system clock
nRESET  in  1  synchronous active-low reset
CH_REQ  in  NCH  per-channel request; rising edge (sampled vs previous cycle) starts one access
CH_WE  in  NCH  1 = write, 0 = read; sampled at grant
CH_BURST  in  NCH  read burst flag; sampled at grant; ignored for writes
CH_ADDR  in  NCH*AW  per-channel word address, packed, channel 0 in LSBs
CH_DIN  in  NCH*16  per-channel write data
CH_BS  in  NCH*2  per-channel byte strobes {UDS,LDS}; 2'b00 is treated as 2'b11
CH_DOUT  out  NCH*RDW  per-channel read data register
CH_DONE  out  NCH  one-cycle completion pulse (reads and writes)
CH_PEND  out  NCH  request latched or running, not yet done
SDRAM_RD  out  1  read command
SDRAM_WR  out  1  write command
SDRAM_BURST  out  1  burst read
SDRAM_ADDR  out  AW  command address
SDRAM_DIN  out  16  write data
SDRAM_BS  out  2  byte strobes
SDRAM_DOUT  in  RDW  read data from controller
SDRAM_READY  in  1  controller idle; falls when a command is accepted
DL_EN  in  1  ROM download active; suspends arbitration
DL_WR  in  1  download write strobe
DL_ADDR  in  AW  download word address
DL_DATA  in  16  download data

Behaviour:
- Reset (nRESET=0, synchronous): all pending, aging and running state is cleared. CH_DONE, CH_PEND and CH_DOUT are 0. SDRAM_BURST is 0 and SDRAM_BS is 2'b11. SDRAM_RD and SDRAM_WR are cleared unless DL_EN=1, so a download write in flight survives. Reset mid-access abandons the access: no DONE is issued and its data is discarded.
- Request latch:
  - A rising edge on CH_REQ[i] sets pend[i]. An edge while pend[i] is already set is merged (lost).
  - An edge in the same cycle the arbiter is idle counts as grantable that cycle; there is no one-cycle latch penalty.
- Controller state machine:
  - IDLE: SDRAM_READY=1, RD=0, WR=0.
  - CMD: RD or WR asserted, waiting for READY to fall.
  - BUSY: READY=0.
  - Transitions:
    - IDLE -> CMD on grant.
    - CMD -> BUSY when a READY 1->0 edge is seen (registered old_ready); RD and WR are cleared that cycle.
    - BUSY -> IDLE when READY=1.
- Completion: on the first cycle in IDLE after BUSY, if a channel is running:
  - read: CH_DOUT[i] <= SDRAM_DOUT; CH_DONE[i] pulses one cycle; pend[i] clears.
  - write: CH_DONE[i] pulses; pend[i] clears.
  - A new grant may be issued in the same cycle as the completion (back-to-back).
- Arbitration, evaluated only in IDLE with DL_EN=0:
  - The candidate set is pend and not running.
  - If any candidate has age == AGE_MAX, the lowest-index such candidate wins. Otherwise the lowest-index candidate wins.
  - The winner's age resets to 0. Every other candidate's age increments, saturating at AGE_MAX.
  - A non-pending channel's age is held at 0.
- Grant outputs, registered:
  - SDRAM_ADDR, SDRAM_DIN, SDRAM_BS come from the winner.
  - SDRAM_BURST = CH_BURST & ~CH_WE.
  - SDRAM_RD = ~CH_WE, SDRAM_WR = CH_WE.
  - Latency is 1 cycle from the grantable edge to the command on the outputs.
- Download bypass: DL_EN & DL_WR loads SDRAM_ADDR=DL_ADDR, SDRAM_DIN=DL_DATA, BS=2'b11, WR=1, overriding any grant that cycle. While DL_EN=1, no channel is granted; pending requests are retained.
- CH_PEND[i] = pend[i] or running on i; it is combinational from registers.
- Widths: all address handling is pass-through; no offset arithmetic inside the block (clients pre-remap).

Test Plan:
1. Single read on ch2: addr 0x0123456, burst=1; controller drops READY 2 cycles later, returns DOUT=0x1122334455667788 -> SDRAM_RD/BURST=1 one cycle after edge, RD clears on READY fall, CH_DOUT[2]=0x1122334455667788, CH_DONE[2] one pulse.
2. Simultaneous edges on ch0..ch3 (all reads) -> grant order 0,1,2,3; four DONE pulses in that order, back-to-back with no idle cycles between completion and next command.
3. Starvation, AGE_MAX=2: ch0 and ch1 re-request immediately after each DONE, ch3 pending -> ch3 granted after it has lost 2 grants (third access overall).
4. Write on ch1: BS=2'b01, DIN=0xABCD -> SDRAM_WR=1, BS=01, DIN=0xABCD, CH_DOUT[1] unchanged, CH_DONE[1] pulse; then BS=00 -> SDRAM_BS=11.
5. DL_EN=1 with DL_WR pulse (addr 0x40, data 0x5A5A) while ch0 is pending -> WR with BS=11 issued, ch0 not granted until DL_EN=0, then ch0 served.
6. nRESET asserted during BUSY with DL_EN=0 -> RD/WR=0, CH_PEND=0, no CH_DONE; after release, a new edge on ch0 is served normally.
